// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
//   Back end of the calculator datapath. Takes an 11-bit two's-complement
//   result, converts its magnitude to four BCD digits with a sequential
//   double-dabble engine, and scans the sign plus four digits onto a
//   5-position multiplexed, active-low 7-segment display.
//
//   Optional feature macro: LEAD_ZERO_BLANK_EN
//     defined   -> leading-zero digits at positions 3..1 are blanked
//     undefined -> all four digits are always shown (e.g. +7 -> " 0007")
//
// Parameters
//   REFRESH_DIV  clk cycles each digit position stays lit (>= 2)
//
// Ports
//   clk      in   1   system clock
//   rst_n    in   1   asynchronous reset, active-low
//   load     in   1   single-cycle strobe: sample data_in, start conversion
//   data_in  in  11   result, two's complement, -1024..+1023
//   busy     out  1   conversion in progress
//   done     out  1   one-cycle pulse: new value committed to display
//   an       out  5   anode enables, active-low one-hot; an[0]=units, an[4]=sign
//   seg      out  7   segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [10:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [4:0]  an,
  output logic [6:0]  seg
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_next;

  // Conversion working registers
  logic        sign_work;
  logic [10:0] mag;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  bit_cnt;

  // Display registers, only ever written at COMMIT so the shown value is atomic
  logic            disp_sign;
  logic [3:0][3:0] disp_digit;
`ifdef LEAD_ZERO_BLANK_EN
  // Bit 0 (units) is tied low so the units digit is never blanked
  logic [3:0]      disp_blank;
`endif

  // Scan state
  logic [CNT_W-1:0] scan_cnt;
  logic [2:0]       scan_idx;
  logic [6:0]       seg_next;
  logic [3:0]       cur_digit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 4'd10) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state and conversion datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the display registers are few flops, not a memory, so they sit
      // on the async reset; a reset mid-conversion must show 0, not stale data.
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      sign_work  <= 1'b0;
      mag        <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      disp_sign  <= 1'b0;
      disp_digit <= '0;
`ifdef LEAD_ZERO_BLANK_EN
      disp_blank <= 4'b1110;
`endif
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (load) begin
            sign_work <= data_in[10];
            // -1024 negates to 11'h400, which read unsigned is 1024
            mag       <= data_in[10] ? (~data_in + 11'd1) : data_in;
            bcd       <= '0;
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          bit_cnt    <= bit_cnt + 4'd1;
        end
        COMMIT: begin
          disp_sign  <= sign_work;
          disp_digit <= bcd;
`ifdef LEAD_ZERO_BLANK_EN
          disp_blank <= {bcd[15:12] == 4'd0,
                         bcd[15:8]  == 8'd0,
                         bcd[15:4]  == 12'd0,
                         1'b0};
`endif
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Segment decode for the position currently being scanned
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    cur_digit = disp_digit[scan_idx[1:0]];
    if (scan_idx == 3'd4) begin
      seg_next = disp_sign ? 7'h3F : 7'h7F;
    end else begin
      seg_next = digit_to_seg(cur_digit);
`ifdef LEAD_ZERO_BLANK_EN
      if (disp_blank[scan_idx[1:0]]) seg_next = 7'h7F;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh scan: an and seg are registered together from the same index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an       <= 5'b11111;
      seg      <= 7'h7F;
    end else begin
      an  <= ~(5'b00001 << scan_idx);
      seg <= seg_next;
      if (scan_cnt == CNT_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == 3'd4) ? 3'd0 : scan_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_display.sv
// -----------------------------------------------------------------------------
// tb_result_display
//   Self-checking bench for result_display with REFRESH_DIV = 4. Expected
//   display contents come from plain decimal arithmetic on the loaded value.
// -----------------------------------------------------------------------------
module tb_result_display;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [10:0] data_in = '0;
  logic        busy;
  logic        done;
  logic [4:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  result_display #(.REFRESH_DIV(RD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .an      (an),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int to_signed(input logic [10:0] v);
    return v[10] ? int'(v) - 2048 : int'(v);
  endfunction

  function automatic logic [6:0] exp_seg(input int pos, input bit sgn, input int mag);
    int p10;
    p10 = 1;
    for (int k = 0; k < pos; k++) p10 = p10 * 10;
    if (pos == 4) return sgn ? 7'h3F : 7'h7F;
`ifdef LEAD_ZERO_BLANK_EN
    if (pos > 0 && mag < p10) return 7'h7F;
`endif
    return seg_tab[(mag / p10) % 10];
  endfunction

  function automatic int an_pos(input logic [4:0] a);
    for (int i = 0; i < 5; i++) begin
      if (a === ~(5'b00001 << i)) return i;
    end
    return -1;
  endfunction

  // ---------------- helpers ----------------
  task automatic check_display(input string name, input bit sgn, input int mag);
    logic [4:0] seen;
    int p;
    seen = '0;
    repeat (2) @(posedge clk);
    repeat (5 * RD + 2) begin
      @(posedge clk);
      #1;
      p = an_pos(an);
      checks++;
      if (p < 0) begin
        errors++;
        $display("FAIL %s an_onehot: got %b", name, an);
      end else begin
        seen[p] = 1'b1;
        if (seg !== exp_seg(p, sgn, mag)) begin
          errors++;
          $display("FAIL %s seg pos%0d: got %h want %h", name, p, seg, exp_seg(p, sgn, mag));
        end
      end
    end
    checks++;
    if (seen !== 5'h1F) begin
      errors++;
      $display("FAIL %s scan_cover: got %b want 11111", name, seen);
    end
  endtask

  task automatic load_value(input logic [10:0] v);
    @(negedge clk);
    data_in = v;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic run_conv(input string name, input logic [10:0] v);
    int busy_cnt, done_cnt, done_at, sv;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    load_value(v);
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    checks++;
    if (done_at !== 12) begin
      errors++;
      $display("FAIL %s done_latency: got %0d want 12", name, done_at);
    end
    checks++;
    if (busy_cnt !== 12) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want 12", name, busy_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt);
    end
    sv = to_signed(v);
    check_display(name, sv < 0, (sv < 0) ? -sv : sv);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [4:0] exp_an;
    rst_n = 1'b0;
    #23;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset busy_done: got %b%b want 00", busy, done);
    end
    checks++;
    if (an !== 5'b11111 || seg !== 7'h7F) begin
      errors++;
      $display("FAIL reset an_seg: got %b/%h want 11111/7f", an, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5 * RD; k++) begin
      @(posedge clk);
      #1;
      exp_an = ~(5'b00001 << (k / RD));
      checks++;
      if (an !== exp_an) begin
        errors++;
        $display("FAIL reset_scan an k=%0d: got %b want %b", k, an, exp_an);
      end
      checks++;
      if (seg !== exp_seg(k / RD, 1'b0, 0)) begin
        errors++;
        $display("FAIL reset_scan seg k=%0d: got %h want %h", k, seg, exp_seg(k / RD, 1'b0, 0));
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_scan idle k=%0d: busy %b done %b want 0 0", k, busy, done);
      end
    end
  endtask

  task automatic test_boundaries();
    run_conv("max_1023", 11'd1023);
    run_conv("min_-1024", 11'h400);
    run_conv("minus_one", 11'h7FF);
    run_conv("zero", 11'd0);
    run_conv("seven", 11'd7);
  endtask

  task automatic test_random();
    logic [10:0] v;
    for (int n = 0; n < 6; n++) begin
      v = 11'($urandom_range(0, 2047));
      run_conv($sformatf("rand_%0d", to_signed(v)), v);
    end
  endtask

  task automatic test_load_while_busy();
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    load_value(11'd5);
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == 2) begin
        data_in = 11'd9;
        load    = 1'b1;
      end
      if (i == 3) load = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL busy_load done_pulses: got %0d want 1", done_cnt);
    end
    checks++;
    if (done_at !== 12) begin
      errors++;
      $display("FAIL busy_load done_latency: got %0d want 12", done_at);
    end
    checks++;
    if (busy_cnt !== 12) begin
      errors++;
      $display("FAIL busy_load busy_cycles: got %0d want 12", busy_cnt);
    end
    check_display("busy_load", 1'b0, 5);
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    load_value(11'd42);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy_done: got %b%b want 00", busy, done);
    end
    checks++;
    if (an !== 5'b11111 || seg !== 7'h7F) begin
      errors++;
      $display("FAIL reset_mid an_seg: got %b/%h want 11111/7f", an, seg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid done_pulses: got %0d want 0", done_cnt);
    end
    check_display("reset_mid", 1'b0, 0);
    run_conv("after_reset_42", 11'd42);
  endtask

  task automatic test_back_to_back();
    int t1, gap;
    t1 = -1;
    load_value(11'd12);
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) t1 = i;
    end
    checks++;
    if (t1 !== 12) begin
      errors++;
      $display("FAIL b2b first_done: got %0d want 12", t1);
    end
    data_in = 11'd34;
    load    = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    gap  = 1;
    while (!done && gap < 40) begin
      @(posedge clk);
      #1;
      gap++;
    end
    checks++;
    if (gap !== 13) begin
      errors++;
      $display("FAIL b2b done_gap: got %0d want 13", gap);
    end
    check_display("b2b", 1'b0, 34);
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_random();
    test_load_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
